soc_tb: RTL and testbench

SOC_TB -- requirements
Module: soc_tb

---
 rtl/soc_tb_pkg.sv | 32 +++
 rtl/soc_tb_if.sv | 10 +
 rtl/soc_tb_rx.sv | 111 +++++++++++
 rtl/soc_tb.sv | 105 ++++++++++
 tb/tb_soc_tb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/soc_tb_pkg.sv
// Shared frame constants, FSM state types and frame-byte helpers for the
// point-to-point serial link node.
package soc_tb_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hD3;
  localparam int         FRAME_BYTES   = 6;
  localparam int         PAYLOAD_BYTES = 4;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_t;
  typedef enum logic [1:0] {TX_WAIT, TX_SEND, TX_DONE} tx_state_t;

  function automatic logic [7:0] payload_byte(input logic [3:0] id, input logic [3:0] k);
    return {id, k};
  endfunction

  function automatic logic [7:0] checksum(input logic [3:0] id);
    logic [7:0] sum;
    sum = 8'd0;
    for (int k = 0; k < PAYLOAD_BYTES; k++) sum = sum + payload_byte(id, 4'(k));
    return sum;
  endfunction

  // Byte idx of the frame sent by node id: sync, payload, then checksum.
  function automatic logic [7:0] frame_byte(input logic [3:0] id, input logic [2:0] idx);
    logic [7:0] b;
    if (idx == 3'd0) b = SYNC_BYTE;
    else if (idx <= 3'(PAYLOAD_BYTES)) b = payload_byte(id, {1'b0, idx - 3'd1});
    else b = checksum(id);
    return b;
  endfunction

endpackage

// File: rtl/soc_tb_if.sv
// Serial link and status bundle of one node; master is the node, slave its environment.
interface soc_tb_if;
  logic antena_in;
  logic antena_out;
  logic trap;
  logic finish;

  modport master (input antena_in, output antena_out, output trap, output finish);
  modport slave  (output antena_in, input antena_out, input trap, input finish);
endinterface

// File: rtl/soc_tb_rx.sv
// Frame receiver: two-flop synchroniser, mid-bit sampling, byte-by-byte check
// against the peer node's expected frame.
module soc_tb_rx
  import soc_tb_pkg::*;
#(
  parameter logic [3:0] ID         = 4'd0,
  parameter int         BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic done,
  output logic good,
  output logic err
);

  localparam int             CW        = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]     PEER      = ID ^ 4'd1;
  localparam logic [2:0]     LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic          sync_p0, sync_p1, sync_p2;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt, byte_idx, byte_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          good_q, good_nxt, err_q, err_nxt;

  // Stage p0/p1 synchronise the line; p2 holds the previous synced level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      good_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_p0  <= line;
      sync_p1  <= sync_p0;
      sync_p2  <= sync_p1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      good_q   <= good_nxt;
      err_q    <= err_nxt;
    end
  end

  always_ff @(posedge clk) shreg <= shreg_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    shreg_nxt = shreg;
    good_nxt  = good_q;
    err_nxt   = err_q;
    case (state)
      RX_IDLE: begin
        if (sync_p1 && !sync_p2) begin
          state_nxt = RX_START;
          cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // A start bit that is gone by its midpoint is treated as line noise.
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = sync_p1 ? RX_DATA : RX_IDLE;
        end else cnt_nxt = cnt + CW'(1);
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {sync_p1, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else bit_nxt = bit_idx + 3'd1;
        end else cnt_nxt = cnt + CW'(1);
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (sync_p1 || (shreg != frame_byte(PEER, byte_idx))) begin
            err_nxt   = 1'b1;
            state_nxt = RX_DONE;
          end else if (byte_idx == LAST_BYTE) begin
            good_nxt  = 1'b1;
            state_nxt = RX_DONE;
          end else begin
            byte_nxt  = byte_idx + 3'd1;
            state_nxt = RX_IDLE;
          end
        end else cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = RX_DONE;
    endcase
  end

  assign done = (state == RX_DONE);
  assign good = good_q;
  assign err  = err_q;

endmodule

// File: rtl/soc_tb.sv
// Link node: sends one frame after a start-up delay, checks the peer's frame,
// and raises a sticky finish or trap flag.
module soc_tb
  import soc_tb_pkg::*;
#(
  parameter logic [3:0] ID         = 4'd0,
  parameter int         BIT_CYCLES = 16,
  parameter int         TX_DELAY   = 32,
  parameter int         TIMEOUT    = 4096
) (
  input  logic     clk,
  input  logic     reset,
  soc_tb_if.master bus
);

  localparam int             TW         = $clog2(TX_DELAY > BIT_CYCLES ? TX_DELAY : BIT_CYCLES) + 1;
  localparam logic [TW-1:0]  DELAY_LAST = TW'(TX_DELAY - 1);
  localparam logic [TW-1:0]  BIT_LAST   = TW'(BIT_CYCLES - 1);
  localparam logic [2:0]     LAST_BYTE  = 3'(FRAME_BYTES - 1);
  localparam int             OW         = $clog2(TIMEOUT) + 1;
  localparam logic [OW-1:0]  TMO_LAST   = OW'(TIMEOUT - 1);

  tx_state_t     tx_state, tx_state_nxt;
  logic [TW-1:0] tx_cnt, tx_cnt_nxt;
  logic [3:0]    tx_bit, tx_bit_nxt;
  logic [2:0]    tx_byte, tx_byte_nxt;
  logic [9:0]    tx_frame_bits;
  logic [OW-1:0] tmr;
  logic          timer_hit, trap_q, finish_q, fin_cond, trap_cond;
  logic          rx_done, rx_good, rx_err;

  soc_tb_rx #(.ID(ID), .BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk   (clk),
    .reset (reset),
    .line  (bus.antena_in),
    .done  (rx_done),
    .good  (rx_good),
    .err   (rx_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_WAIT;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_byte  <= tx_byte_nxt;
    end
  end

  // tx_cnt first measures the start-up delay, then the cycles within each line bit.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_byte_nxt  = tx_byte;
    case (tx_state)
      TX_WAIT: begin
        if (tx_cnt == DELAY_LAST) begin
          tx_state_nxt = TX_SEND;
          tx_cnt_nxt   = '0;
        end else tx_cnt_nxt = tx_cnt + TW'(1);
      end
      TX_SEND: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bit == 4'd9) begin
            tx_bit_nxt = '0;
            if (tx_byte == LAST_BYTE) tx_state_nxt = TX_DONE;
            else tx_byte_nxt = tx_byte + 3'd1;
          end else tx_bit_nxt = tx_bit + 4'd1;
        end else tx_cnt_nxt = tx_cnt + TW'(1);
      end
      default: tx_state_nxt = TX_DONE;
    endcase
  end

  // Line bit order: start (1), data LSB first, stop (0).
  assign tx_frame_bits  = {1'b0, frame_byte(ID, tx_byte), 1'b1};
  assign bus.antena_out = (tx_state == TX_SEND) && tx_frame_bits[tx_bit];

  assign timer_hit = (tmr == TMO_LAST);
  assign fin_cond  = (tx_state == TX_DONE) && rx_done && rx_good && !trap_q;
  assign trap_cond = !finish_q && !fin_cond && (rx_err || timer_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr      <= '0;
      trap_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      if (!timer_hit) tmr <= tmr + OW'(1);
      if (fin_cond)   finish_q <= 1'b1;
      if (trap_cond)  trap_q   <= 1'b1;
    end
  end

  assign bus.trap   = trap_q;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_soc_tb.sv
// Directed bench: a cross-connected ID0/ID1 pair plus a lone ID0 node whose
// receive line is driven by hand-built frames.
module tb_soc_tb;

  localparam int BIT = 16;
  localparam int TXD = 32;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra_n, rs_n, drv;
  int   total = 0;
  int   bad   = 0;

  soc_tb_if if_a0 ();
  soc_tb_if if_a1 ();
  soc_tb_if if_s ();

  assign if_a0.antena_in = if_a1.antena_out;
  assign if_a1.antena_in = if_a0.antena_out;
  assign if_s.antena_in  = drv;

  soc_tb #(.ID(4'd0), .BIT_CYCLES(BIT), .TX_DELAY(TXD), .TIMEOUT(TMO)) dut_a0 (
    .clk(clk), .reset(ra_n), .bus(if_a0.master));
  soc_tb #(.ID(4'd1), .BIT_CYCLES(BIT), .TX_DELAY(TXD), .TIMEOUT(TMO)) dut_a1 (
    .clk(clk), .reset(ra_n), .bus(if_a1.master));
  soc_tb #(.ID(4'd0), .BIT_CYCLES(BIT), .TX_DELAY(TXD), .TIMEOUT(TMO)) dut_s (
    .clk(clk), .reset(rs_n), .bus(if_s.master));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from reset release until node a0 raises its start bit.
  task automatic wait_tx_start(output int n);
    n = 0;
    while (if_a0.antena_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Called on the first sample of a start bit; returns on the first sample of the next one.
  task automatic capture_byte(output logic [9:0] word);
    repeat (BIT / 2) tick();
    word[9] = if_a0.antena_out;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) tick();
      word[8 - i] = if_a0.antena_out;
    end
    repeat (BIT) tick();
    word[0] = if_a0.antena_out;
    repeat (BIT / 2) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drv = 1'b1;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      drv = b[i];
      repeat (BIT) tick();
    end
    drv = stop;
    repeat (BIT) tick();
    drv = 1'b0;
  endtask

  task automatic restart_single();
    rs_n = 1'b0;
    drv  = 1'b0;
    repeat (3) tick();
    rs_n = 1'b1;
  endtask

  task automatic test_reset();
    ra_n = 1'b0;
    rs_n = 1'b0;
    drv  = 1'b0;
    repeat (5) tick();
    total++; if (if_a0.antena_out !== 1'b0) begin bad++; $display("FAIL rst_a0_out got=%b want=0", if_a0.antena_out); end
    total++; if (if_a1.antena_out !== 1'b0) begin bad++; $display("FAIL rst_a1_out got=%b want=0", if_a1.antena_out); end
    total++; if (if_s.antena_out !== 1'b0) begin bad++; $display("FAIL rst_s_out got=%b want=0", if_s.antena_out); end
    total++; if (if_a0.trap !== 1'b0 || if_a1.trap !== 1'b0) begin bad++; $display("FAIL rst_pair_trap got=%b%b want=00", if_a0.trap, if_a1.trap); end
    total++; if (if_a0.finish !== 1'b0 || if_a1.finish !== 1'b0) begin bad++; $display("FAIL rst_pair_finish got=%b%b want=00", if_a0.finish, if_a1.finish); end
    total++; if (if_s.trap !== 1'b0 || if_s.finish !== 1'b0) begin bad++; $display("FAIL rst_s_flags got=%b%b want=00", if_s.trap, if_s.finish); end
  endtask

  task automatic test_pair_frame();
    logic [7:0] exp_a0 [6];
    logic [9:0] word;
    int n, m;
    exp_a0 = '{8'hD3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
    ra_n = 1'b1;
    wait_tx_start(n);
    total++; if (n != TXD) begin bad++; $display("FAIL pair_tx_delay got=%0d want=%0d", n, TXD); end
    total++; if (if_a1.antena_out !== 1'b1) begin bad++; $display("FAIL pair_a1_start got=%b want=1", if_a1.antena_out); end
    for (int k = 0; k < 6; k++) begin
      capture_byte(word);
      total++;
      if (word !== {1'b1, exp_a0[k][0], exp_a0[k][1], exp_a0[k][2], exp_a0[k][3],
                    exp_a0[k][4], exp_a0[k][5], exp_a0[k][6], exp_a0[k][7], 1'b0}) begin
        bad++; $display("FAIL pair_byte%0d got=%b want_data=%h", k, word, exp_a0[k]);
      end
    end
    m = 0;
    while (!(if_a0.finish === 1'b1 && if_a1.finish === 1'b1) && m < 1000) begin
      tick();
      m++;
    end
    total++; if (if_a0.finish !== 1'b1 || if_a1.finish !== 1'b1) begin bad++; $display("FAIL pair_finish got=%b%b want=11", if_a0.finish, if_a1.finish); end
    total++; if (if_a0.trap !== 1'b0 || if_a1.trap !== 1'b0) begin bad++; $display("FAIL pair_trap got=%b%b want=00", if_a0.trap, if_a1.trap); end
    repeat (200) tick();
    total++; if (if_a0.antena_out !== 1'b0 || if_a1.antena_out !== 1'b0) begin bad++; $display("FAIL pair_idle_after got=%b%b want=00", if_a0.antena_out, if_a1.antena_out); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] word;
    int n, m;
    ra_n = 1'b0;
    tick();
    ra_n = 1'b1;
    repeat (TXD + 3 * 10 * BIT + 40) tick();
    ra_n = 1'b0;
    #1;
    total++; if (if_a0.antena_out !== 1'b0 || if_a1.antena_out !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%b%b want=00", if_a0.antena_out, if_a1.antena_out); end
    repeat (5) tick();
    total++; if (if_a0.finish !== 1'b0 || if_a0.trap !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b want=00", if_a0.finish, if_a0.trap); end
    ra_n = 1'b1;
    wait_tx_start(n);
    total++; if (n != TXD) begin bad++; $display("FAIL mid_restart_delay got=%0d want=%0d", n, TXD); end
    capture_byte(word);
    total++; if (word !== 10'b1_11001011_0) begin bad++; $display("FAIL mid_restart_sync got=%b want=%b", word, 10'b1_11001011_0); end
    m = 0;
    while (!(if_a0.finish === 1'b1 && if_a1.finish === 1'b1) && m < 1200) begin
      tick();
      m++;
    end
    total++; if (if_a0.finish !== 1'b1 || if_a1.finish !== 1'b1 || if_a0.trap !== 1'b0) begin bad++; $display("FAIL mid_finish got=%b%b trap=%b want=11 trap=0", if_a0.finish, if_a1.finish, if_a0.trap); end
  endtask

  task automatic test_bad_checksum();
    restart_single();
    repeat (10) tick();
    send_byte(8'hD3, 1'b0);
    for (int k = 0; k < 4; k++) send_byte({4'h1, 4'(k)}, 1'b0);
    total++; if (if_s.trap !== 1'b0) begin bad++; $display("FAIL csum_pre_trap got=%b want=0", if_s.trap); end
    send_byte(8'h4F, 1'b0);
    repeat (20) tick();
    total++; if (if_s.trap !== 1'b1) begin bad++; $display("FAIL csum_trap got=%b want=1", if_s.trap); end
    repeat (100) tick();
    total++; if (if_s.finish !== 1'b0 || if_s.trap !== 1'b1) begin bad++; $display("FAIL csum_sticky got_finish=%b got_trap=%b want 0/1", if_s.finish, if_s.trap); end
  endtask

  task automatic test_timeout();
    int n;
    restart_single();
    n = 0;
    while (if_s.trap !== 1'b1 && n < TMO + 500) begin
      tick();
      n++;
    end
    total++; if (n != TMO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO); end
    total++; if (if_s.finish !== 1'b0) begin bad++; $display("FAIL timeout_finish got=%b want=0", if_s.finish); end
  endtask

  task automatic test_glitch_then_frame();
    int m;
    restart_single();
    repeat (5) tick();
    drv = 1'b1;
    repeat (3) tick();
    drv = 1'b0;
    repeat (30) tick();
    total++; if (if_s.trap !== 1'b0) begin bad++; $display("FAIL glitch_trap got=%b want=0", if_s.trap); end
    // Checksum of the ID 1 payload 10 11 12 13 is 0x46.
    send_byte(8'hD3, 1'b0);
    for (int k = 0; k < 4; k++) send_byte({4'h1, 4'(k)}, 1'b0);
    send_byte(8'h46, 1'b0);
    m = 0;
    while (if_s.finish !== 1'b1 && m < 500) begin
      tick();
      m++;
    end
    total++; if (if_s.finish !== 1'b1 || if_s.trap !== 1'b0) begin bad++; $display("FAIL glitch_frame got_finish=%b got_trap=%b want 1/0", if_s.finish, if_s.trap); end
  endtask

  task automatic test_stop_bit();
    restart_single();
    repeat (5) tick();
    send_byte(8'hD3, 1'b0);
    send_byte(8'h10, 1'b0);
    drv = 1'b1;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      drv = (i == 0 || i == 4);
      repeat (BIT) tick();
    end
    total++; if (if_s.trap !== 1'b0) begin bad++; $display("FAIL stop_pre_trap got=%b want=0", if_s.trap); end
    drv = 1'b1;
    repeat (BIT) tick();
    drv = 1'b0;
    total++; if (if_s.trap !== 1'b1) begin bad++; $display("FAIL stop_trap got=%b want=1", if_s.trap); end
    repeat (50) tick();
    total++; if (if_s.trap !== 1'b1 || if_s.finish !== 1'b0) begin bad++; $display("FAIL stop_sticky got_trap=%b got_finish=%b want 1/0", if_s.trap, if_s.finish); end
  endtask

  initial begin
    test_reset();
    test_pair_frame();
    test_reset_midframe();
    test_bad_checksum();
    test_timeout();
    test_glitch_then_frame();
    test_stop_bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
